// File: rtl/lfsr_sng_pkg.sv
// Shared constants and tap-position helper for the stochastic number generator.
package lfsr_sng_pkg;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'h8016;
  localparam logic [23:0] TAPS_24 = 24'hE10000;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  // State bit feeding bit k of channel c's random word.
  function automatic int tap_index(input int c, input int k, input int width,
                                   input int ch_off, input int stride);
    return (c * ch_off + k * stride) % width;
  endfunction

endpackage

// File: rtl/sng_cmp.sv
// One stochastic-bit channel: random word vs probability, registered on enable.
module sng_cmp #(
  parameter int OUT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [OUT_W-1:0] rand_i,
  input  logic [OUT_W-1:0] prob_i,
  output logic             sn_o
);

  logic sn_q, sn_d;

  always_comb begin
    sn_d = sn_q;
    if (en_i) sn_d = (rand_i < prob_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sn_q <= 1'b0;
    else          sn_q <= sn_d;
  end

  assign sn_o = sn_q;

endmodule

// File: rtl/lfsr_sng.sv
// Multi-channel LFSR stochastic number generator with seed load and frame marking.
// Optional zero-seed lockup guard: define LFSR_SNG_LOCKUP_GUARD_EN.
module lfsr_sng
  import lfsr_sng_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = TAPS_16,
  parameter logic [WIDTH-1:0] RESET_SEED = 16'hACE1,
  parameter int               OUT_W      = 8,
  parameter int               NCH        = 2,
  parameter int               BIT_STRIDE = 3,
  parameter int               CH_OFF     = 8,
  parameter int               FRAME_LEN  = 256
) (
  input  logic                 TRIG,
  input  logic                 RESET_N,
  input  logic                 EN,
  input  logic                 LOAD,
  input  logic [WIDTH-1:0]     SEED,
  input  logic [NCH*OUT_W-1:0] PROB,
  output logic [NCH*OUT_W-1:0] RAND,
  output logic [NCH-1:0]       SN,
  output logic                 FRAME_END,
  output logic                 LOCKUP
);

  localparam int             FCW  = $clog2(FRAME_LEN);
  localparam logic [FCW-1:0] LAST = FCW'(FRAME_LEN - 1);

  logic [WIDTH-1:0] lfsr_q, lfsr_d, seed_eff;
  logic [FCW-1:0]   fc_q, fc_d;
  logic             fe_q, fe_d;
  logic             fb;

  assign fb = ^(lfsr_q & TAPS);

`ifdef LFSR_SNG_LOCKUP_GUARD_EN
  logic lock_q, lock_d;
  assign seed_eff = (SEED == '0) ? WIDTH'(1) : SEED;
  assign lock_d   = lock_q | (LOAD && (SEED == '0));

  always_ff @(posedge TRIG or negedge RESET_N) begin
    if (!RESET_N) lock_q <= 1'b0;
    else          lock_q <= lock_d;
  end
  assign LOCKUP = lock_q;
`else
  assign seed_eff = SEED;
  assign LOCKUP   = 1'b0;
`endif

  always_comb begin
    lfsr_d = lfsr_q;
    fc_d   = fc_q;
    fe_d   = 1'b0;
    if (LOAD) begin
      lfsr_d = seed_eff;
      fc_d   = '0;
    end else if (EN) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], fb};
      fc_d   = (fc_q == LAST) ? '0 : fc_q + FCW'(1);
      fe_d   = (fc_q == LAST);
    end
  end

  always_ff @(posedge TRIG or negedge RESET_N) begin
    if (!RESET_N) begin
      lfsr_q <= RESET_SEED;
      fc_q   <= '0;
      fe_q   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      fc_q   <= fc_d;
      fe_q   <= fe_d;
    end
  end

  assign FRAME_END = fe_q;

  // Decorrelated taps: each channel reads a strided, offset view of the state.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    for (genvar k = 0; k < OUT_W; k++) begin : g_bit
      assign RAND[c*OUT_W + k] = lfsr_q[tap_index(c, k, WIDTH, CH_OFF, BIT_STRIDE)];
    end

    sng_cmp #(.OUT_W(OUT_W)) u_cmp (
      .clk_i   (TRIG),
      .rst_n_i (RESET_N),
      .en_i    (EN & ~LOAD),
      .rand_i  (RAND[c*OUT_W +: OUT_W]),
      .prob_i  (PROB[c*OUT_W +: OUT_W]),
      .sn_o    (SN[c])
    );
  end

endmodule
